// File: rtl/fpsqrt_frac_bist_pkg.sv
// Shared types, widths and the xorshift64 generator for the fractional sqrt BIST.
package fpsqrt_frac_bist_pkg;

  localparam int OP_W  = 53;
  localparam int RES_W = 54;
  localparam int SQ_W  = 108;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT_RES,
    SQ,
    CMP,
    GAP,
    DONE
  } state_e;

  function automatic logic [63:0] xorshift64(input logic [63:0] x);
    logic [63:0] y;
    y = x ^ (x << 13);
    y = y ^ (y >> 7);
    y = y ^ (y << 17);
    return y;
  endfunction

endpackage

// File: rtl/fpsqrt_frac_bist_if.sv
// Start/finish valid-ready channels between the BIST (master) and the sqrt engine (slave).
interface fpsqrt_frac_bist_if;
  import fpsqrt_frac_bist_pkg::*;

  logic             dut_start_valid_o;
  logic             dut_start_ready_i;
  logic [OP_W-1:0]  dut_op_o;
  logic             dut_is_odd_o;
  logic             dut_finish_valid_i;
  logic             dut_finish_ready_o;
  logic [RES_W-1:0] dut_res_i;

  modport master (
    output dut_start_valid_o, dut_op_o, dut_is_odd_o, dut_finish_ready_o,
    input  dut_start_ready_i, dut_finish_valid_i, dut_res_i
  );

  modport slave (
    input  dut_start_valid_o, dut_op_o, dut_is_odd_o, dut_finish_ready_o,
    output dut_start_ready_i, dut_finish_valid_i, dut_res_i
  );

endinterface

// File: rtl/fpsqrt_frac_chk.sv
// Registered exact check of a sqrt result: passes iff R = floor(sqrt(S)), decided by squaring R.
module fpsqrt_frac_chk
  import fpsqrt_frac_bist_pkg::*;
(
  input  logic             clk,
  input  logic [OP_W-1:0]  i_op,
  input  logic             i_is_odd,
  input  logic [RES_W-1:0] i_res,
  output logic             o_pass
);

  logic [SQ_W-1:0] r_sq;
  logic [SQ_W-1:0] r_s;
  logic [SQ_W-1:0] r_two_r;
  logic [SQ_W-1:0] w_s;
  logic [SQ_W-1:0] w_diff;

  // An odd exponent contributes one extra factor of two before the root is taken.
  assign w_s = i_is_odd ? {i_op, 55'd0} : {1'b0, i_op, 54'd0};

  always_ff @(posedge clk) begin
    r_sq    <= {54'd0, i_res} * {54'd0, i_res};
    r_s     <= w_s;
    r_two_r <= {53'd0, i_res, 1'b0};
  end

  assign w_diff = r_s - r_sq;
  assign o_pass = (r_sq <= r_s) && (w_diff <= r_two_r);

endmodule

// File: rtl/fpsqrt_frac_bist.sv
// Initiator and self-checker for the fractional sqrt engine: issues LFSR operands,
// accepts results with random backpressure, counts errors and captures the first failure.
module fpsqrt_frac_bist
  import fpsqrt_frac_bist_pkg::*;
#(
  parameter int MAX_ERR = 10,
  parameter int DELAY_W = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                run_i,
  input  logic [31:0]         num_tests_i,
  input  logic [63:0]         seed_i,
  fpsqrt_frac_bist_if.master  dut,
  output logic                busy_o,
  output logic                done_o,
  output logic [31:0]         acq_count_o,
  output logic [31:0]         err_count_o,
  output logic                err_valid_o,
  output logic [OP_W-1:0]     err_op_o,
  output logic                err_is_odd_o,
  output logic [RES_W-1:0]    err_res_o
);

  state_e             r_state;
  logic [63:0]        r_lfsr;
  logic [OP_W-1:0]    r_op;
  logic               r_is_odd;
  logic               r_start_valid;
  logic               r_finish_ready;
  logic [DELAY_W-1:0] r_cnt;
  logic [RES_W-1:0]   r_res;
  logic               r_busy;
  logic               r_done;
  logic [31:0]        r_acq;
  logic [31:0]        r_err;
  logic               r_err_valid;
  logic [OP_W-1:0]    r_err_op;
  logic               r_err_is_odd;
  logic [RES_W-1:0]   r_err_res;

  logic [63:0]        w_seed;
  logic [DELAY_W-1:0] w_stall;
  logic [DELAY_W-1:0] w_gap;
  logic               w_pass;
  logic [31:0]        w_acq_next;
  logic [31:0]        w_err_next;

  assign w_seed     = (seed_i == 64'd0) ? 64'd1 : seed_i;
  assign w_stall    = r_lfsr[62 -: DELAY_W];
  assign w_gap      = r_lfsr[59 -: DELAY_W];
  assign w_acq_next = (r_acq == '1) ? r_acq : r_acq + 32'd1;
  assign w_err_next = (w_pass || r_err == '1) ? r_err : r_err + 32'd1;

  fpsqrt_frac_chk u_chk (
    .clk      (clk),
    .i_op     (r_op),
    .i_is_odd (r_is_odd),
    .i_res    (r_res),
    .o_pass   (w_pass)
  );

  // The operand register is reloaded only on entry to ISSUE, so it still names the
  // vector under test during SQ/CMP even though the LFSR has already moved on.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state        <= IDLE;
      r_lfsr         <= 64'd1;
      r_op           <= '0;
      r_is_odd       <= 1'b0;
      r_start_valid  <= 1'b0;
      r_finish_ready <= 1'b0;
      r_cnt          <= '0;
      r_res          <= '0;
      r_busy         <= 1'b0;
      r_done         <= 1'b0;
      r_acq          <= '0;
      r_err          <= '0;
      r_err_valid    <= 1'b0;
      r_err_op       <= '0;
      r_err_is_odd   <= 1'b0;
      r_err_res      <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (run_i && num_tests_i != 32'd0) begin
            r_state       <= ISSUE;
            r_lfsr        <= w_seed;
            r_op          <= {1'b1, w_seed[51:0]};
            r_is_odd      <= w_seed[63];
            r_start_valid <= 1'b1;
            r_busy        <= 1'b1;
            r_done        <= 1'b0;
            r_acq         <= '0;
            r_err         <= '0;
            r_err_valid   <= 1'b0;
            r_err_op      <= '0;
            r_err_is_odd  <= 1'b0;
            r_err_res     <= '0;
          end
        end
        ISSUE: begin
          if (dut.dut_start_ready_i) begin
            r_state        <= WAIT_RES;
            r_start_valid  <= 1'b0;
            r_lfsr         <= xorshift64(r_lfsr);
            r_cnt          <= w_stall;
            r_finish_ready <= (w_stall == '0);
          end
        end
        WAIT_RES: begin
          if (dut.dut_finish_valid_i && r_finish_ready) begin
            r_state        <= SQ;
            r_res          <= dut.dut_res_i;
            r_finish_ready <= 1'b0;
          end else if (r_cnt != '0) begin
            r_cnt          <= r_cnt - DELAY_W'(1);
            r_finish_ready <= (r_cnt == DELAY_W'(1));
          end
        end
        SQ: r_state <= CMP;
        CMP: begin
          r_acq <= w_acq_next;
          r_err <= w_err_next;
          if (!w_pass && !r_err_valid) begin
            r_err_valid  <= 1'b1;
            r_err_op     <= r_op;
            r_err_is_odd <= r_is_odd;
            r_err_res    <= r_res;
          end
          if (w_err_next >= 32'(MAX_ERR) || w_acq_next >= num_tests_i) begin
            r_state <= DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end else begin
            r_state <= GAP;
            r_cnt   <= w_gap;
          end
        end
        GAP: begin
          if (!run_i) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end else if (r_cnt == '0) begin
            r_state       <= ISSUE;
            r_op          <= {1'b1, r_lfsr[51:0]};
            r_is_odd      <= r_lfsr[63];
            r_start_valid <= 1'b1;
          end else begin
            r_cnt <= r_cnt - DELAY_W'(1);
          end
        end
        DONE: begin
          if (!run_i) begin
            r_state <= IDLE;
            r_done  <= 1'b0;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign dut.dut_start_valid_o  = r_start_valid;
  assign dut.dut_op_o           = r_op;
  assign dut.dut_is_odd_o       = r_is_odd;
  assign dut.dut_finish_ready_o = r_finish_ready;

  assign busy_o       = r_busy;
  assign done_o       = r_done;
  assign acq_count_o  = r_acq;
  assign err_count_o  = r_err;
  assign err_valid_o  = r_err_valid;
  assign err_op_o     = r_err_op;
  assign err_is_odd_o = r_err_is_odd;
  assign err_res_o    = r_err_res;

endmodule

// File: tb/tb_fpsqrt_frac_bist.sv
// Directed bench for fpsqrt_frac_bist: plays the sqrt engine and checks counts, captures and handshake timing.
module tb_fpsqrt_frac_bist;

  localparam int MODE_EXACT = 0;
  localparam int MODE_PLUS1 = 1;
  localparam int MODE_FIXED = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        runI = 1'b0;
  logic [31:0] numTests = 32'd0;
  logic [63:0] seed = 64'd0;
  logic        busy;
  logic        done;
  logic [31:0] acqCount;
  logic [31:0] errCount;
  logic        errValid;
  logic [52:0] errOp;
  logic        errIsOdd;
  logic [53:0] errRes;

  int          assertCount = 0;
  int          failCount = 0;
  logic [63:0] lfsrModel = 64'd1;

  fpsqrt_frac_bist_if dutIf ();

  fpsqrt_frac_bist dut (
    .clk          (clk),
    .rst          (rst),
    .run_i        (runI),
    .num_tests_i  (numTests),
    .seed_i       (seed),
    .dut          (dutIf),
    .busy_o       (busy),
    .done_o       (done),
    .acq_count_o  (acqCount),
    .err_count_o  (errCount),
    .err_valid_o  (errValid),
    .err_op_o     (errOp),
    .err_is_odd_o (errIsOdd),
    .err_res_o    (errRes)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] xs(input logic [63:0] x);
    logic [63:0] v;
    v = x;
    v = v ^ (v << 13);
    v = v ^ (v >> 7);
    v = v ^ (v << 17);
    return v;
  endfunction

  function automatic logic [107:0] sFor(input logic [52:0] op, input logic odd);
    logic [107:0] s;
    s = {55'd0, op};
    s = odd ? (s << 55) : (s << 54);
    return s;
  endfunction

  // Bit-serial integer square root, independent of the squaring check in the design.
  function automatic logic [53:0] isqrt(input logic [107:0] s);
    logic [53:0]  r;
    logic [53:0]  t;
    logic [107:0] sq;
    r = '0;
    for (int i = 53; i >= 0; i--) begin
      t  = r | (54'd1 << i);
      sq = {54'd0, t} * {54'd0, t};
      if (sq <= s) r = t;
    end
    return r;
  endfunction

  task automatic checkOutput(input string tag, input logic [127:0] observed, input logic [127:0] expected);
    assertCount++;
    assert (observed === expected)
    else begin
      failCount++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic run, input logic [31:0] n, input logic [63:0] s);
    runI      = run;
    numTests  = n;
    seed      = s;
    lfsrModel = (s == 64'd0) ? 64'd1 : s;
  endtask

  task automatic startHandshake(output logic [52:0] op, output logic odd);
    int waitCycles;
    waitCycles = 0;
    dutIf.dut_start_ready_i = 1'b1;
    while (!dutIf.dut_start_valid_o && waitCycles < 50) begin
      @(negedge clk);
      waitCycles++;
    end
    checkOutput("start_valid_seen", dutIf.dut_start_valid_o, 1'b1);
    op  = dutIf.dut_op_o;
    odd = dutIf.dut_is_odd_o;
    checkOutput("op_hidden_bit", op[52], 1'b1);
    @(negedge clk);
    dutIf.dut_start_ready_i = 1'b0;
    checkOutput("start_valid_drop", dutIf.dut_start_valid_o, 1'b0);
  endtask

  task automatic finishHandshake(input logic [53:0] res);
    int waitCycles;
    waitCycles = 0;
    dutIf.dut_finish_valid_i = 1'b1;
    dutIf.dut_res_i          = res;
    while (!dutIf.dut_finish_ready_o && waitCycles < 50) begin
      @(negedge clk);
      waitCycles++;
    end
    checkOutput("finish_ready_seen", dutIf.dut_finish_ready_o, 1'b1);
    @(negedge clk);
    dutIf.dut_finish_valid_i = 1'b0;
    checkOutput("finish_ready_drop", dutIf.dut_finish_ready_o, 1'b0);
  endtask

  task automatic serveVector(input int mode, input logic [53:0] fixedRes,
                             output logic [52:0] op, output logic odd);
    logic [53:0] r;
    startHandshake(op, odd);
    checkOutput("op_model", op, {1'b1, lfsrModel[51:0]});
    checkOutput("odd_model", odd, lfsrModel[63]);
    lfsrModel = xs(lfsrModel);
    r = isqrt(sFor(op, odd));
    if (mode == MODE_PLUS1) r = r + 54'd1;
    else if (mode == MODE_FIXED) r = fixedRes;
    finishHandshake(r);
  endtask

  task automatic waitDone();
    int waitCycles;
    waitCycles = 0;
    while (!done && waitCycles < 50) begin
      @(negedge clk);
      waitCycles++;
    end
    checkOutput("done_seen", done, 1'b1);
  endtask

  task automatic endRun();
    runI = 1'b0;
    @(negedge clk);
    checkOutput("done_cleared", done, 1'b0);
    checkOutput("busy_idle", busy, 1'b0);
  endtask

  // The two channel strobes must never overlap.
  always @(negedge clk) begin
    if (!rst) checkOutput("valid_ready_exclusive",
                          dutIf.dut_start_valid_o & dutIf.dut_finish_ready_o, 1'b0);
  end

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [52:0] op;
    logic        odd;
    logic [52:0] firstOp;
    logic        firstOdd;
    logic [52:0] holdOp;
    int          waitCycles;

    dutIf.dut_start_ready_i  = 1'b0;
    dutIf.dut_finish_valid_i = 1'b0;
    dutIf.dut_res_i          = '0;

    // Reset state
    repeat (3) @(negedge clk);
    checkOutput("rst_start_valid", dutIf.dut_start_valid_o, 1'b0);
    checkOutput("rst_finish_ready", dutIf.dut_finish_ready_o, 1'b0);
    checkOutput("rst_op", dutIf.dut_op_o, 53'd0);
    checkOutput("rst_busy", busy, 1'b0);
    checkOutput("rst_done", done, 1'b0);
    checkOutput("rst_acq", acqCount, 32'd0);
    checkOutput("rst_err", errCount, 32'd0);
    checkOutput("rst_err_valid", errValid, 1'b0);
    rst = 1'b0;
    @(negedge clk);

    // num_tests=0 never starts a run
    applyStimulus(1'b1, 32'd0, 64'h1234);
    repeat (3) @(negedge clk);
    checkOutput("zero_tests_busy", busy, 1'b0);
    checkOutput("zero_tests_valid", dutIf.dut_start_valid_o, 1'b0);
    runI = 1'b0;
    @(negedge clk);

    // Test 1: exact result for 1.0 with even exponent; stall bits are zero
    applyStimulus(1'b1, 32'd1, 64'h0010_0000_0000_0000);
    startHandshake(op, odd);
    checkOutput("t1_op", op, 53'h10_0000_0000_0000);
    checkOutput("t1_odd", odd, 1'b0);
    checkOutput("t1_ready_first_cycle", dutIf.dut_finish_ready_o, 1'b1);
    checkOutput("t1_busy", busy, 1'b1);
    finishHandshake(54'h20_0000_0000_0000);
    waitDone();
    checkOutput("t1_acq", acqCount, 32'd1);
    checkOutput("t1_err", errCount, 32'd0);
    checkOutput("t1_err_valid", errValid, 1'b0);
    repeat (2) @(negedge clk);
    checkOutput("t1_done_held", done, 1'b1);
    endRun();

    // Test 2: result one below the true root fails the remainder bound
    applyStimulus(1'b1, 32'd1, 64'h0010_0000_0000_0000);
    serveVector(MODE_FIXED, 54'h1F_FFFF_FFFF_FFFF, op, odd);
    waitDone();
    checkOutput("t2_acq", acqCount, 32'd1);
    checkOutput("t2_err", errCount, 32'd1);
    checkOutput("t2_err_valid", errValid, 1'b1);
    checkOutput("t2_err_res", errRes, 54'h1F_FFFF_FFFF_FFFF);
    checkOutput("t2_err_op", errOp, 53'h10_0000_0000_0000);
    checkOutput("t2_err_odd", errIsOdd, 1'b0);
    endRun();

    // Test 3: 1000 exact responses
    applyStimulus(1'b1, 32'd1000, 64'h1234);
    for (int v = 0; v < 1000; v++) serveVector(MODE_EXACT, 54'd0, op, odd);
    waitDone();
    checkOutput("t3_acq", acqCount, 32'd1000);
    checkOutput("t3_err", errCount, 32'd0);
    checkOutput("t3_err_valid", errValid, 1'b0);
    endRun();

    // Test 4: every result too large by one; run stops at the error limit
    applyStimulus(1'b1, 32'd100, 64'hDEAD_BEEF_0BAD_F00D);
    serveVector(MODE_PLUS1, 54'd0, firstOp, firstOdd);
    for (int v = 1; v < 10; v++) serveVector(MODE_PLUS1, 54'd0, op, odd);
    waitDone();
    checkOutput("t4_acq", acqCount, 32'd10);
    checkOutput("t4_err", errCount, 32'd10);
    checkOutput("t4_err_valid", errValid, 1'b1);
    checkOutput("t4_err_op", errOp, firstOp);
    checkOutput("t4_err_odd", errIsOdd, firstOdd);
    checkOutput("t4_err_res", errRes, isqrt(sFor(firstOp, firstOdd)) + 54'd1);
    checkOutput("t4_no_reissue", dutIf.dut_start_valid_o, 1'b0);
    endRun();

    // Test 5: engine holds start_ready low; operand must stay put
    applyStimulus(1'b1, 32'd2, 64'h5555);
    waitCycles = 0;
    while (!dutIf.dut_start_valid_o && waitCycles < 50) begin
      @(negedge clk);
      waitCycles++;
    end
    checkOutput("t5_valid_seen", dutIf.dut_start_valid_o, 1'b1);
    holdOp = dutIf.dut_op_o;
    checkOutput("t5_hold_op_model", holdOp, {1'b1, lfsrModel[51:0]});
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      checkOutput("t5_valid_stable", dutIf.dut_start_valid_o, 1'b1);
      checkOutput("t5_op_stable", dutIf.dut_op_o, holdOp);
    end
    serveVector(MODE_EXACT, 54'd0, op, odd);
    serveVector(MODE_EXACT, 54'd0, op, odd);
    waitDone();
    checkOutput("t5_acq", acqCount, 32'd2);
    checkOutput("t5_err", errCount, 32'd0);
    endRun();

    // Test 6: reset during WAIT_RES, then replay from the same seed
    applyStimulus(1'b1, 32'd5, 64'hCAFE);
    serveVector(MODE_EXACT, 54'd0, firstOp, firstOdd);
    startHandshake(op, odd);
    checkOutput("t6_second_op", op, {1'b1, lfsrModel[51:0]});
    rst  = 1'b1;
    runI = 1'b0;
    @(negedge clk);
    checkOutput("t6_rst_start_valid", dutIf.dut_start_valid_o, 1'b0);
    checkOutput("t6_rst_finish_ready", dutIf.dut_finish_ready_o, 1'b0);
    checkOutput("t6_rst_op", dutIf.dut_op_o, 53'd0);
    checkOutput("t6_rst_busy", busy, 1'b0);
    checkOutput("t6_rst_acq", acqCount, 32'd0);
    checkOutput("t6_rst_err_op", errOp, 53'd0);
    rst = 1'b0;
    @(negedge clk);
    applyStimulus(1'b1, 32'd5, 64'hCAFE);
    startHandshake(op, odd);
    checkOutput("t6_replay_op", op, firstOp);
    checkOutput("t6_replay_odd", odd, firstOdd);
    finishHandshake(isqrt(sFor(op, odd)));
    // Abort from GAP: outputs keep their values
    runI = 1'b0;
    repeat (4) @(negedge clk);
    checkOutput("t6_abort_busy", busy, 1'b0);
    checkOutput("t6_abort_done", done, 1'b0);
    checkOutput("t6_abort_acq", acqCount, 32'd1);

    // Seed 0 is replaced by 1
    applyStimulus(1'b1, 32'd1, 64'd0);
    serveVector(MODE_EXACT, 54'd0, op, odd);
    checkOutput("seed0_op", op, 53'h10_0000_0000_0001);
    waitDone();
    checkOutput("seed0_acq", acqCount, 32'd1);
    endRun();

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
